// File: rtl/adder_mul_pkg.sv
// Shared types and default width for the sequential shift-add multiplier.
package adder_mul_pkg;

    // Default operand width; product is twice this wide.
    localparam int MUL_N = 16;

    // Controller states: waiting for operands, shifting/adding, holding the result.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

endpackage

// File: rtl/Adder.sv
// N-bit ripple-carry adder built from a chain of Full_Adder cells.
module Adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    output logic [N-1:0] S,
    output logic         C_out
);

    // carry[i] feeds bit i; carry[N] is the final carry out.
    logic [N:0] carry;

    assign carry[0] = C_in;

    for (genvar i = 0; i < N; i++) begin : g_bit
        Full_Adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .c_in (carry[i]),
            .s    (S[i]),
            .c_out(carry[i+1])
        );
    end

    assign C_out = carry[N];

endmodule

// File: rtl/Full_Adder.sv
// One-bit full adder cell used to build the ripple-carry Adder.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/adder_mul_seq.sv
// Sequential unsigned shift-add multiplier. One shared N-bit Adder performs
// one partial-product add per cycle; N cycles form the exact 2N-bit product.
module adder_mul_seq
    import adder_mul_pkg::*;
#(
    parameter int N = MUL_N
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int             CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    mul_state_t       state;
    logic [N-1:0]     m;      // multiplicand
    logic [N-1:0]     p;      // accumulator, high half of the product
    logic [N-1:0]     q;      // multiplier, shifted out as the low half fills in
    logic [CNT_W-1:0] cnt;

    logic [N-1:0]     add_b;
    logic [N-1:0]     sum;
    logic             add_cout;

    // Add the multiplicand only when the current multiplier bit is set.
    assign add_b = q[0] ? m : '0;

    Adder #(.N(N)) u_adder (
        .A    (p),
        .B    (add_b),
        .C_in (1'b0),
        .S    (sum),
        .C_out(add_cout)
    );

    // {P,Q} is the product once RUN completes; both halves are registers.
    assign product = {p, q};

    // Controller FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: data registers are reset too, so product reads 0 out of reset.
            state     <= IDLE;
            m         <= '0;
            p         <= '0;
            q         <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: handshake outputs are set alongside the next state so they
            // never depend combinationally on inputs.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m        <= a_in;
                        q        <= b_in;
                        p        <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // Shift the sum right through P into Q; carry lands in P's MSB.
                    p   <= {add_cout, sum[N-1:1]};
                    q   <= {sum[0], q[N-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/adder_mul_seq.md
Name: adder_mul_seq

Overview:
Sequential unsigned shift-add multiplier controller. It time-shares one instance of the team's N-bit ripple-carry Adder, one add per cycle, to form a 2N-bit product. Operands enter and the result leaves over valid/ready handshakes. It sits beside the ALU as the multi-cycle MUL unit, so no combinational multiplier array is needed.

Parameters:
N, 16, operand width; also the width of the shared Adder instance (Adder#(.N(N))).

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands (high only in IDLE)
a_in  input  N  multiplicand, unsigned
b_in  input  N  multiplier, unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2N  unsigned product {P,Q}
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- Reset (rstn=0, asynchronous, any state):
  - state=IDLE; M, P, Q, cnt all cleared to 0.
  - Outputs: in_ready=1, out_valid=0, busy=0, product=0.
  - Reset mid-RUN or mid-DONE aborts the operation and discards the result.
- Registers:
  - M (N bits): multiplicand.
  - P (N bits): accumulator, high half.
  - Q (N bits): multiplier, becomes the low half.
  - cnt: $clog2(N)+1 bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: M<=a_in, Q<=b_in, P<=0, cnt<=0, go to RUN.
- RUN (in_ready=0, busy=1):
  - Shared Adder is driven every cycle with A=P, B=(Q[0] ? M : 0), C_in=0.
  - Each edge: P<={C_out, S[N-1:1]}, Q<={S[0], Q[N-1:1]}, cnt<=cnt+1.
  - When cnt==N-1 at an edge, go to DONE. Exactly N RUN cycles.
- DONE:
  - out_valid=1, product={P,Q}; both held stable until out_ready=1.
  - On out_valid && out_ready: go to IDLE.
- Latency:
  - Fixed, independent of operand values (no early exit on zero).
  - Acceptance edge at cycle k; out_valid first high after edge k+N.
- Throughput:
  - One product per N+2 cycles minimum.
  - in_ready is low in DONE even if out_ready=1, so there is one bubble cycle in IDLE.
- Ignored inputs:
  - in_valid during RUN/DONE is ignored; no latch, no error.
  - out_ready outside DONE is ignored.
- Width rules:
  - Product is exact: max (2^N-1)^2 fits in 2N bits.
  - Adder C_out is never lost; it enters P[N-1] on the shift.
- a_in and b_in are sampled only at the acceptance edge; later changes have no effect.
- The product output is registered; there is no combinational path from inputs to outputs except none.

Decomposition:
- Package adder_mul_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t.
  - Default width constant MUL_N=16.
- Sub-module: exactly one instance of the existing Adder (Adder#(.N(N))), in turn built from Full_Adder cells.
- FSM, operand registers and counter live in adder_mul_seq itself. No further sub-modules.

Test Plan:
- Basic: rstn pulse, then a_in=3, b_in=5, in_valid=1 for 1 cycle, out_ready=1 -> out_valid high exactly 16 edges after acceptance, product=0x0000000F, then IDLE with in_ready=1.
- Max operands: a_in=0xFFFF, b_in=0xFFFF -> product=0xFFFE0001, which exercises Adder C_out into P[15]. a_in=0xFFFF, b_in=0x0001 -> 0x0000FFFF.
- Zero and fixed latency: a_in=0x0000, b_in=0x1234 -> product=0 after exactly 16 RUN cycles. a_in=0x8000, b_in=0x8000 -> 0x40000000.
- Backpressure and ignored input: out_ready=0 for 5 cycles in DONE -> out_valid and product stay constant. in_valid pulses during RUN/DONE with other operands -> no effect, result unchanged.
- Reset mid-operation: assert rstn=0 at RUN cycle 7, asynchronously -> out_valid=0, busy=0, in_ready=1 immediately. The next op 7*9 returns 0x0000003F.
- Random regression: 1000 random a_in/b_in with random out_ready stalls -> each product equals a_in*b_in, and no result is lost or duplicated.
